// File: rtl/pci_master_pkg.sv
// Shared types and constants for the PCI master arbiter: response codes,
// field widths, per-direction FSM states and registered command/response records.
package pci_master_pkg;

    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;
    localparam int PID_W  = 2;
    localparam int PORT_W = 2;

    typedef enum logic [1:0] {
        RESP_OK     = 2'b00,
        RESP_EXOK   = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_RESP
    } dir_state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    typedef struct packed {
        logic [PID_W-1:0] pid;
        logic [LEN_W-1:0] len;
        resp_e            err;
    } resp_t;

endpackage

// File: rtl/pci_master_arbiter_if.sv
// Bundles the requester-side and downstream-controller-side buses of the arbiter;
// master is the arbiter's view, slave is the view of the surrounding agents.
interface pci_master_arbiter_if
    import pci_master_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]        p_wcmd_valid, p_wcmd_ready;
    logic [PID_W*NREQ-1:0]  p_wcmd_id;
    logic [LEN_W*NREQ-1:0]  p_wcmd_len;
    logic [ADDR_W*NREQ-1:0] p_wcmd_addr;

    logic [NREQ-1:0]        p_rcmd_valid, p_rcmd_ready;
    logic [PID_W*NREQ-1:0]  p_rcmd_id;
    logic [LEN_W*NREQ-1:0]  p_rcmd_len;
    logic [ADDR_W*NREQ-1:0] p_rcmd_addr;

    logic [NREQ-1:0]        p_wresp_valid, p_wresp_ready;
    logic [PID_W-1:0]       p_wresp_id;
    logic [LEN_W-1:0]       p_wresp_len;
    logic [1:0]             p_wresp_err;

    logic [NREQ-1:0]        p_rresp_valid, p_rresp_ready;
    logic [PID_W-1:0]       p_rresp_id;
    logic [LEN_W-1:0]       p_rresp_len;
    logic [1:0]             p_rresp_err;

    logic [NREQ-1:0]        p_rdata_valid, p_rdata_ready;
    logic [DATA_W-1:0]      p_rdata_din;

    logic                   wcmd_valid, wcmd_ready;
    logic [ID_W-1:0]        wcmd_id;
    logic [LEN_W-1:0]       wcmd_len;
    logic [ADDR_W-1:0]      wcmd_addr;

    logic                   rcmd_valid, rcmd_ready;
    logic [ID_W-1:0]        rcmd_id;
    logic [LEN_W-1:0]       rcmd_len;
    logic [ADDR_W-1:0]      rcmd_addr;

    logic                   wresp_valid, wresp_ready;
    logic [ID_W-1:0]        wresp_id;
    logic [LEN_W-1:0]       wresp_len;
    logic [1:0]             wresp_err;

    logic                   rresp_valid, rresp_ready;
    logic [ID_W-1:0]        rresp_id;
    logic [LEN_W-1:0]       rresp_len;
    logic [1:0]             rresp_err;

    logic                   rdata_valid, rdata_ready;
    logic [DATA_W-1:0]      rdata_din;

    modport master (
        input  p_wcmd_valid, p_wcmd_id, p_wcmd_len, p_wcmd_addr,
        output p_wcmd_ready,
        input  p_rcmd_valid, p_rcmd_id, p_rcmd_len, p_rcmd_addr,
        output p_rcmd_ready,
        output p_wresp_valid, p_wresp_id, p_wresp_len, p_wresp_err,
        input  p_wresp_ready,
        output p_rresp_valid, p_rresp_id, p_rresp_len, p_rresp_err,
        input  p_rresp_ready,
        output p_rdata_valid, p_rdata_din,
        input  p_rdata_ready,
        output wcmd_valid, wcmd_id, wcmd_len, wcmd_addr,
        input  wcmd_ready,
        output rcmd_valid, rcmd_id, rcmd_len, rcmd_addr,
        input  rcmd_ready,
        input  wresp_valid, wresp_id, wresp_len, wresp_err,
        output wresp_ready,
        input  rresp_valid, rresp_id, rresp_len, rresp_err,
        output rresp_ready,
        input  rdata_valid, rdata_din,
        output rdata_ready
    );

    modport slave (
        output p_wcmd_valid, p_wcmd_id, p_wcmd_len, p_wcmd_addr,
        input  p_wcmd_ready,
        output p_rcmd_valid, p_rcmd_id, p_rcmd_len, p_rcmd_addr,
        input  p_rcmd_ready,
        input  p_wresp_valid, p_wresp_id, p_wresp_len, p_wresp_err,
        output p_wresp_ready,
        input  p_rresp_valid, p_rresp_id, p_rresp_len, p_rresp_err,
        output p_rresp_ready,
        input  p_rdata_valid, p_rdata_din,
        output p_rdata_ready,
        input  wcmd_valid, wcmd_id, wcmd_len, wcmd_addr,
        output wcmd_ready,
        input  rcmd_valid, rcmd_id, rcmd_len, rcmd_addr,
        output rcmd_ready,
        output wresp_valid, wresp_id, wresp_len, wresp_err,
        input  wresp_ready,
        output rresp_valid, rresp_id, rresp_len, rresp_err,
        input  rresp_ready,
        output rdata_valid, rdata_din,
        input  rdata_ready
    );

endinterface

// File: rtl/pci_rr_arbiter.sv
// Round-robin request picker: searches from the port after the last grant and
// remembers the winner only when the caller strobes advance.
module pci_rr_arbiter
    import pci_master_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic              advance,
    output logic [NREQ-1:0]   grant,
    output logic [PORT_W-1:0] grant_idx
);

    logic [PORT_W-1:0] last_q;
    logic              found;
    int                cand;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(last_q) + 1 + k) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = PORT_W'(cand);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_W'(NREQ - 1);
        end else if (advance) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/pci_master_arbiter.sv
// Multiplexes NREQ requesters onto one downstream master controller with an
// independent one-outstanding IDLE->CMD->WAIT->RESP FSM per direction.
module pci_master_arbiter
    import pci_master_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pci_master_arbiter_if.master bus,
    output logic                 stray_rdata,
    output logic                 id_mismatch
);

    if (NREQ < 2 || NREQ > 4 || MAX_OUT != 1) begin : g_param_check
        $error("pci_master_arbiter: NREQ must be 2..4 and MAX_OUT must be 1");
    end

    dir_state_e        w_state_q, w_state_d, r_state_q, r_state_d;
    cmd_t              w_cmd_q, w_cmd_d, r_cmd_q, r_cmd_d;
    resp_t             w_resp_q, r_resp_q;
    logic [PORT_W-1:0] w_owner_q, r_owner_q;
    logic [NREQ-1:0]   w_grant, r_grant;
    logic [PORT_W-1:0] w_gidx, r_gidx;
    logic              w_advance, r_advance;
    logic              r_route;

    pci_rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.p_wcmd_valid),
        .advance   (w_advance),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    pci_rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.p_rcmd_valid),
        .advance   (r_advance),
        .grant     (r_grant),
        .grant_idx (r_gidx)
    );

    // Field capture mux: downstream id carries the port number in its upper bits.
    always_comb begin
        w_cmd_d = '0;
        r_cmd_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_cmd_d.id   = {PORT_W'(i), bus.p_wcmd_id[PID_W*i +: PID_W]};
                w_cmd_d.len  = bus.p_wcmd_len[LEN_W*i +: LEN_W];
                w_cmd_d.addr = bus.p_wcmd_addr[ADDR_W*i +: ADDR_W];
            end
            if (r_grant[i]) begin
                r_cmd_d.id   = {PORT_W'(i), bus.p_rcmd_id[PID_W*i +: PID_W]};
                r_cmd_d.len  = bus.p_rcmd_len[LEN_W*i +: LEN_W];
                r_cmd_d.addr = bus.p_rcmd_addr[ADDR_W*i +: ADDR_W];
            end
        end
    end

    always_comb begin
        w_state_d         = w_state_q;
        w_advance         = 1'b0;
        bus.wcmd_valid    = 1'b0;
        bus.wcmd_id       = w_cmd_q.id;
        bus.wcmd_len      = w_cmd_q.len;
        bus.wcmd_addr     = w_cmd_q.addr;
        bus.p_wcmd_ready  = '0;
        bus.wresp_ready   = 1'b0;
        bus.p_wresp_valid = '0;
        bus.p_wresp_id    = w_resp_q.pid;
        bus.p_wresp_len   = w_resp_q.len;
        bus.p_wresp_err   = w_resp_q.err;
        case (w_state_q)
            ST_IDLE: if (|bus.p_wcmd_valid) begin
                w_advance = 1'b1;
                w_state_d = ST_CMD;
            end
            ST_CMD: begin
                bus.wcmd_valid = 1'b1;
                if (bus.wcmd_ready) begin
                    bus.p_wcmd_ready[w_owner_q] = 1'b1;
                    w_state_d                   = ST_WAIT;
                end
            end
            ST_WAIT: if (bus.wresp_valid) w_state_d = ST_RESP;
            ST_RESP: begin
                bus.p_wresp_valid[w_owner_q] = 1'b1;
                if (bus.p_wresp_ready[w_owner_q]) begin
                    bus.wresp_ready = 1'b1;
                    w_state_d       = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        r_state_d         = r_state_q;
        r_advance         = 1'b0;
        bus.rcmd_valid    = 1'b0;
        bus.rcmd_id       = r_cmd_q.id;
        bus.rcmd_len      = r_cmd_q.len;
        bus.rcmd_addr     = r_cmd_q.addr;
        bus.p_rcmd_ready  = '0;
        bus.rresp_ready   = 1'b0;
        bus.p_rresp_valid = '0;
        bus.p_rresp_id    = r_resp_q.pid;
        bus.p_rresp_len   = r_resp_q.len;
        bus.p_rresp_err   = r_resp_q.err;
        case (r_state_q)
            ST_IDLE: if (|bus.p_rcmd_valid) begin
                r_advance = 1'b1;
                r_state_d = ST_CMD;
            end
            ST_CMD: begin
                bus.rcmd_valid = 1'b1;
                if (bus.rcmd_ready) begin
                    bus.p_rcmd_ready[r_owner_q] = 1'b1;
                    r_state_d                   = ST_WAIT;
                end
            end
            ST_WAIT: if (bus.rresp_valid) r_state_d = ST_RESP;
            ST_RESP: begin
                bus.p_rresp_valid[r_owner_q] = 1'b1;
                if (bus.p_rresp_ready[r_owner_q]) begin
                    bus.rresp_ready = 1'b1;
                    r_state_d       = ST_IDLE;
                end
            end
            default: r_state_d = ST_IDLE;
        endcase
    end

    // Read data follows the read owner while a read is in flight; otherwise it is sunk.
    // rst forces ready low so every handshake output is quiet during reset.
    assign r_route = (r_state_q == ST_CMD) || (r_state_q == ST_WAIT);

    always_comb begin
        bus.p_rdata_valid = '0;
        bus.p_rdata_din   = bus.rdata_din;
        bus.rdata_ready   = 1'b0;
        if (!rst) begin
            if (r_route) begin
                bus.p_rdata_valid[r_owner_q] = bus.rdata_valid;
                bus.rdata_ready              = bus.p_rdata_ready[r_owner_q];
            end else begin
                bus.rdata_ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= ST_IDLE;
            w_cmd_q   <= '0;
            w_resp_q  <= '0;
            w_owner_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            if (w_advance) begin
                w_cmd_q   <= w_cmd_d;
                w_owner_q <= w_gidx;
            end
            if (w_state_q == ST_WAIT && bus.wresp_valid) begin
                w_resp_q <= '{pid: bus.wresp_id[PID_W-1:0], len: bus.wresp_len,
                              err: resp_e'(bus.wresp_err)};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_cmd_q   <= '0;
            r_resp_q  <= '0;
            r_owner_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (r_advance) begin
                r_cmd_q   <= r_cmd_d;
                r_owner_q <= r_gidx;
            end
            if (r_state_q == ST_WAIT && bus.rresp_valid) begin
                r_resp_q <= '{pid: bus.rresp_id[PID_W-1:0], len: bus.rresp_len,
                              err: resp_e'(bus.rresp_err)};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stray_rdata <= 1'b0;
            id_mismatch <= 1'b0;
        end else begin
            if (bus.rdata_valid && !r_route) stray_rdata <= 1'b1;
            if (w_state_q == ST_WAIT && bus.wresp_valid &&
                bus.wresp_id[ID_W-1 -: PORT_W] != w_owner_q) id_mismatch <= 1'b1;
            if (r_state_q == ST_WAIT && bus.rresp_valid &&
                bus.rresp_id[ID_W-1 -: PORT_W] != r_owner_q) id_mismatch <= 1'b1;
        end
    end

endmodule

// File: doc/pci_master_arbiter.md
PCI_MASTER_ARBITER -- requirements
Module: pci_master_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requester ports, range 2..4.
REQ-002 Parameter: MAX_OUT, default 1, outstanding commands per direction, fixed at 1.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 p_wcmd_valid/p_wcmd_ready  in/out  NREQ  per-port write command handshake.
REQ-006 p_wcmd_id [2*NREQ], p_wcmd_len [8*NREQ], p_wcmd_addr [64*NREQ]  in  per-port write command fields; len is beats minus 1.
REQ-007 p_rcmd_valid/p_rcmd_ready/p_rcmd_id/p_rcmd_len/p_rcmd_addr  in/out  same widths as write  per-port read command.
REQ-008 p_wresp_valid out NREQ, p_wresp_ready in NREQ, p_wresp_id out 2, p_wresp_len out 8, p_wresp_err out 2: shared response bus, valid one-hot.
REQ-009 p_rresp_* : same as p_wresp_* for reads.
REQ-010 p_rdata_valid out NREQ, p_rdata_ready in NREQ, p_rdata_din out 32: read data, routed to the read owner.
REQ-011 wcmd_*/rcmd_* out (ready in), wresp_*/rresp_* in (ready out), rdata_* in (ready out): downstream master-controller ports; id width 4.

Function
REQ-012 Downstream id SHALL be {port[1:0], p_id[1:0]}; len and addr SHALL pass unmodified.
REQ-013 Each direction SHALL run an independent FSM: IDLE -> CMD -> WAIT -> RESP -> IDLE.
REQ-014 IDLE: when any p_*cmd_valid is high, SHALL grant one port by round-robin and register its fields; next state CMD.
REQ-015 Round-robin: search starts at last_grant+1 modulo NREQ; last_grant updates only on grant; after reset the search starts at port 0.
REQ-016 CMD: downstream *cmd_valid high with stable fields; on *cmd_ready, assert p_*cmd_ready[grant] for exactly that cycle; next state WAIT.
REQ-017 Latency: a lone request at cycle N SHALL give downstream valid at N+1.
REQ-018 WAIT: on downstream *resp_valid, capture id/len/err, decode port from id[3:2], hold downstream *resp_ready low; next state RESP.
REQ-019 RESP: p_*resp_valid[port] high with captured fields; on p_*resp_ready[port], pulse downstream *resp_ready for one cycle; next state IDLE.
REQ-020 Read data during rd CMD/WAIT: route rdata to the read owner: p_rdata_valid[owner]=rdata_valid, rdata_ready=p_rdata_ready[owner], combinationally.
REQ-021 rdata_valid outside rd CMD/WAIT: data SHALL be accepted (rdata_ready=1) and discarded, and the sticky status bit stray_rdata (out, 1) SHALL be set.
REQ-022 Response with id[3:2] differing from the granted port: SHALL still route to the granted port and set sticky id_mismatch (out, 1).
REQ-023 A port's write and read MAY both be outstanding; the two directions SHALL never block each other.
REQ-024 Simultaneous valid on all ports: each port SHALL be granted once within NREQ consecutive grants.
REQ-025 A requester dropping valid before grant: no grant; its fields are not sampled.
REQ-026 p_*cmd_ready SHALL never be asserted to a non-granted port.

Reset
REQ-027 On rst: FSMs IDLE, last_grant=NREQ-1, all valid and ready outputs 0, stray_rdata=0, id_mismatch=0.
REQ-028 Registered command and response fields SHALL reset to 0.
REQ-029 rst mid-transaction SHALL abandon it with no response delivered; the downstream controller is reset by the same rst.

Structure
REQ-030 pci_master_pkg SHALL hold RESP_OK/EXOK/SLVERR/DECERR, id width (4) and len width (8).
REQ-031 Sub-module pci_rr_arbiter (NREQ request vector in, one-hot grant plus index out, advance strobe) SHALL be instantiated once per direction.
REQ-032 Sequential logic only in this module and pci_rr_arbiter; routing muxes are combinational.

Verification
REQ-033 Port 2 write, len=3, addr=0x1000 -> wcmd_id=0x8|p_id at N+1; resp err=0 delivered only on p_wresp_valid[2].
REQ-034 All 4 ports request reads continuously -> grant order 0,1,2,3,0; no port starved.
REQ-035 Port 1 write and port 3 read concurrent -> both downstream valids high in the same cycle; responses to ports 1 and 3.
REQ-036 Read len=7 for port 0 with p_rdata_ready toggled -> 8 beats on port 0 only; rdata_ready mirrors p_rdata_ready[0].
REQ-037 rst asserted in WAIT -> all outputs 0 in the same cycle; after release, port 0 has priority.
REQ-038 rdata_valid pulse in IDLE -> stray_rdata=1; no p_rdata_valid asserted.
